lcd_hd44780_responder: RTL and testbench
========================================

# lcd_hd44780_responder

Bus-functional HD44780-compatible character-LCD responder attached to the `lcd_RS`/`lcd_RW`/`lcd_E`/`lcd_data` conduit of the Nios system. It is the display end of the LCD interface: it decodes 8-bit-mode instruction and data cycles, maintains a 128-byte DDRAM, an address counter and a busy timer, and answers busy-flag and data reads. It serves as a synthesizable on-board stand-in and as the simulation model for software LCD drivers; a monitor port exposes DDRAM and control state to checkers.

## Interface
- `BUSY_CYCLES`, 2000: busy duration for ordinary instructions and data writes, in `clk_clk` cycles (≥1).
- `CLEAR_CYCLES`, 82000: busy duration for clear display and return home (≥128).
- `clk_clk`  in  1  single system clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `lcd_RS`  in  1  register select (0 instruction, 1 data).
- `lcd_RW`  in  1  1 read, 0 write.
- `lcd_E`  in  1  enable strobe, asynchronous to `clk_clk`.
- `lcd_data`  inout  8  bus; driven only while synced E=1 and RW=1, else high-Z.
- `mon_addr`  in  7  DDRAM monitor read address.
- `mon_data`  out  8  DDRAM[`mon_addr`], registered.
- `busy`  out  1  busy flag.
- `display_on`, `cursor_on`, `blink_on`  out  1 each  D/C/B bits of display control.
- `violation`  out  1  one-cycle pulse: write received while busy.

## Operation
- `lcd_E`, `lcd_RS`, `lcd_RW`, `lcd_data` pass through 2-flop synchronizers; E edges detected on synced value.
- Write commit on synced E falling edge with RW=0, using RS/data sampled at that edge.
- Write while `busy`=1: discarded, `violation` pulses, no state change.
- Instruction decode (RS=0), highest set bit wins:
  - 0x80–0xFF set DDRAM address: AC←data[6:0], mode←DDRAM.
  - 0x40–0x7F set CGRAM address: mode←CGRAM; AC unchanged; subsequent data writes dropped (CGRAM not modelled).
  - 0x20–0x3F function set: stored N bit only; DL=0 not supported (treated as DL=1).
  - 0x10–0x1F shift: S/C=0 moves AC by ±1 per R/L (bit2); S/C=1 no-op.
  - 0x08–0x0F display control: latch D,C,B.
  - 0x04–0x07 entry mode: latch I/D (bit1); S ignored.
  - 0x02–0x03 return home: AC←0, busy `CLEAR_CYCLES`.
  - 0x01 clear: DDRAM filled with 0x20 at one address per cycle (128 cycles), AC←0, I/D←1, busy `CLEAR_CYCLES`.
  - 0x00: no-op, no busy.
- Data write (RS=1, mode DDRAM): DDRAM[AC]←data, then AC±1 per I/D.
- AC is 7 bits, wraps modulo 128 both directions (0x7F+1→0x00, 0x00−1→0x7F); HD44780 line gaps not modelled.
- Reads: synced E rising with RW=1 latches read value, driven until synced E falls. RS=0 → {busy, AC}; RS=1 → DDRAM[AC], AC±1 applied at E falling. Reads never violate and are allowed while busy.
- FSM: IDLE → BUSY (counter load) → IDLE; CLEAR state runs fill then continues counting in BUSY until `CLEAR_CYCLES` total elapsed.

## Timing
- Reset values: `busy`=0, AC=0, I/D=1, D=C=B=0, `violation`=0, `lcd_data` high-Z, `mon_data`=0, FSM IDLE; DDRAM not reset.
- Write committed 3 clocks after pin-level E falls; `busy`=1 from the following cycle for exactly N cycles (N = `BUSY_CYCLES` or `CLEAR_CYCLES`).
- Read data valid on `lcd_data` 3 clocks after pin-level E rises; E high width ≥5 clocks and E low ≥3 clocks required, shorter pulses unspecified.
- `mon_data` latency 1 cycle; during clear fill reflects partially cleared contents.
- Reset mid-clear or mid-busy: fill aborted, remaining contents retained, `busy`=0 immediately.

## Structure
- Package `lcd_pkg`: instruction-class constants, `DDRAM_DEPTH`=128, `BLANK_CHAR`=8'h20, FSM state enum.
- Sub-module `lcd_ddram`: 128×8 RAM, one write/read port for the core, one read port for monitor.

## Test plan
- Reset, then read RS=0 → bus 0x00; `busy`=0, all flags 0.
- Write 0x01 → `busy` high for `CLEAR_CYCLES`; afterwards `mon_addr`=0x00..0x7F all read 0x20, AC=0.
- Write 0x80|0x7F, data 0x41, data 0x42 → DDRAM[0x7F]=0x41, DDRAM[0x00]=0x42, AC=0x01 (wrap).
- Write 0x04 (decrement), 0x80, data 0x5A → DDRAM[0x00]=0x5A, status read returns 0x7F after busy clears.
- Data write issued 10 cycles after prior write (`BUSY_CYCLES`=2000) → `violation` pulse, DDRAM unchanged; status read during busy returns bit7=1.
- Write 0x0E → `display_on`=1, `cursor_on`=1, `blink_on`=0; reset asserted mid-clear → `busy`=0 next cycle, AC=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, types and instruction decoder for the HD44780 responder
package lcd_pkg;

    localparam int              DDRAM_DEPTH = 128;
    localparam int              AC_W        = 7;
    localparam logic [7:0]      BLANK_CHAR  = 8'h20;
    localparam logic [AC_W-1:0] FILL_LAST   = AC_W'(DDRAM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_e;

    typedef enum logic [3:0] {
        IC_NOP     = 4'd0,
        IC_CLEAR   = 4'd1,
        IC_HOME    = 4'd2,
        IC_ENTRY   = 4'd3,
        IC_DISPLAY = 4'd4,
        IC_SHIFT   = 4'd5,
        IC_FUNC    = 4'd6,
        IC_CGRAM   = 4'd7,
        IC_DDRAM   = 4'd8
    } instr_class_e;

    // The highest set bit of an instruction byte selects its class.
    function automatic instr_class_e decode_instr(input logic [7:0] d);
        instr_class_e c;
        if (d[7])      c = IC_DDRAM;
        else if (d[6]) c = IC_CGRAM;
        else if (d[5]) c = IC_FUNC;
        else if (d[4]) c = IC_SHIFT;
        else if (d[3]) c = IC_DISPLAY;
        else if (d[2]) c = IC_ENTRY;
        else if (d[1]) c = IC_HOME;
        else if (d[0]) c = IC_CLEAR;
        else           c = IC_NOP;
        return c;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 128x8 display data RAM with a core port and a registered monitor port
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [AC_W-1:0] waddr_i,
    input  logic [7:0]      wdata_i,
    input  logic [AC_W-1:0] raddr_i,
    output logic [7:0]      rdata_o,
    input  logic [AC_W-1:0] mon_addr_i,
    output logic [7:0]      mon_data_o
);

    logic [7:0] mem_q [DDRAM_DEPTH];
    logic [7:0] mon_q;

    // Array contents survive reset, like the real display RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    // Monitor read is registered so checkers see a clean one-cycle latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mon_q <= 8'h00;
        end else begin
            mon_q <= mem_q[mon_addr_i];
        end
    end

    assign mon_data_o = mon_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780-compatible 8-bit bus responder with DDRAM and busy timer
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       lcd_RS,
    input  logic       lcd_RW,
    input  logic       lcd_E,
    inout  wire  [7:0] lcd_data,
    input  logic [6:0] mon_addr,
    output logic [7:0] mon_data,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       violation
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    logic            e_s1_q, e_s2_q, e_s3_q;
    logic            rs_s1_q, rs_s2_q;
    logic            rw_s1_q, rw_s2_q;
    logic [7:0]      dat_s1_q, dat_s2_q;

    lcd_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AC_W-1:0] fill_q, fill_d;
    logic [AC_W-1:0] ac_q, ac_d;
    logic            id_q, id_d;
    logic            mode_q, mode_d;
    logic            n_q, n_d;
    logic            disp_q, disp_d;
    logic            cur_q, cur_d;
    logic            blink_q, blink_d;
    logic [7:0]      rd_q, rd_d;
    logic            drive_q, drive_d;
    logic            violation_q, violation_d;

    logic            e_rise, e_fall, wr_evt, rd_fall, busy_w;
    logic [AC_W-1:0] ac_step;
    logic            ram_we;
    logic [AC_W-1:0] ram_waddr;
    logic [7:0]      ram_wdata, ram_rdata;
    logic            load_busy, load_long, load_clear;
    instr_class_e    cls;

    lcd_ddram u_ddram (
        .clk_i      (clk_clk),
        .rst_i      (reset_reset),
        .we_i       (ram_we),
        .waddr_i    (ram_waddr),
        .wdata_i    (ram_wdata),
        .raddr_i    (ac_q),
        .rdata_o    (ram_rdata),
        .mon_addr_i (mon_addr),
        .mon_data_o (mon_data)
    );

    assign e_rise  = e_s2_q & ~e_s3_q;
    assign e_fall  = ~e_s2_q & e_s3_q;
    assign wr_evt  = e_fall & ~rw_s2_q;
    assign rd_fall = e_fall & rw_s2_q;
    assign busy_w  = (state_q != ST_IDLE);
    assign ac_step = id_q ? 7'd1 : 7'h7F;
    assign cls     = decode_instr(dat_s2_q);

    // Two-flop synchronizers for the bus pins plus one extra E stage for edge detection.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            e_s1_q   <= 1'b0;
            e_s2_q   <= 1'b0;
            e_s3_q   <= 1'b0;
            rs_s1_q  <= 1'b0;
            rs_s2_q  <= 1'b0;
            rw_s1_q  <= 1'b0;
            rw_s2_q  <= 1'b0;
            dat_s1_q <= 8'h00;
            dat_s2_q <= 8'h00;
        end else begin
            e_s1_q   <= lcd_E;
            e_s2_q   <= e_s1_q;
            e_s3_q   <= e_s2_q;
            rs_s1_q  <= lcd_RS;
            rs_s2_q  <= rs_s1_q;
            rw_s1_q  <= lcd_RW;
            rw_s2_q  <= rw_s1_q;
            dat_s1_q <= lcd_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Busy timer, clear fill, command decode and read latching.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        ac_d        = ac_q;
        id_d        = id_q;
        mode_d      = mode_q;
        n_d         = n_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        rd_d        = rd_q;
        drive_d     = drive_q;
        violation_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = ac_q;
        ram_wdata   = dat_s2_q;
        load_busy   = 1'b0;
        load_long   = 1'b0;
        load_clear  = 1'b0;

        case (state_q)
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CLEAR: begin
                // One blank per cycle; the timer keeps running so the total
                // busy time covers the fill.
                ram_we    = 1'b1;
                ram_waddr = fill_q;
                ram_wdata = BLANK_CHAR;
                fill_d    = fill_q + 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (fill_q == FILL_LAST) begin
                    state_d = (cnt_q == '0) ? ST_IDLE : ST_BUSY;
                end
            end
            default: ;
        endcase

        if (e_rise && rw_s2_q) begin
            rd_d    = rs_s2_q ? ram_rdata : {busy_w, ac_q};
            drive_d = 1'b1;
        end
        if (e_fall) begin
            drive_d = 1'b0;
        end
        if (rd_fall && rs_s2_q) begin
            ac_d = ac_q + ac_step;
        end

        if (wr_evt) begin
            if (busy_w) begin
                violation_d = 1'b1;
            end else if (rs_s2_q) begin
                // Data aimed at CGRAM is accepted on the bus but not stored.
                if (mode_q) begin
                    ram_we    = 1'b1;
                    ram_waddr = ac_q;
                    ram_wdata = dat_s2_q;
                    ac_d      = ac_q + ac_step;
                end
                load_busy = 1'b1;
            end else begin
                case (cls)
                    IC_DDRAM: begin
                        ac_d      = dat_s2_q[6:0];
                        mode_d    = 1'b1;
                        load_busy = 1'b1;
                    end
                    IC_CGRAM: begin
                        mode_d    = 1'b0;
                        load_busy = 1'b1;
                    end
                    IC_FUNC: begin
                        n_d       = dat_s2_q[3];
                        load_busy = 1'b1;
                    end
                    IC_SHIFT: begin
                        if (!dat_s2_q[3]) begin
                            ac_d = dat_s2_q[2] ? (ac_q + 7'd1) : (ac_q - 7'd1);
                        end
                        load_busy = 1'b1;
                    end
                    IC_DISPLAY: begin
                        disp_d    = dat_s2_q[2];
                        cur_d     = dat_s2_q[1];
                        blink_d   = dat_s2_q[0];
                        load_busy = 1'b1;
                    end
                    IC_ENTRY: begin
                        id_d      = dat_s2_q[1];
                        load_busy = 1'b1;
                    end
                    IC_HOME: begin
                        ac_d      = '0;
                        load_long = 1'b1;
                    end
                    IC_CLEAR: begin
                        ac_d       = '0;
                        id_d       = 1'b1;
                        load_clear = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (load_busy) begin
            state_d = ST_BUSY;
            cnt_d   = BUSY_LOAD;
        end
        if (load_long) begin
            state_d = ST_BUSY;
            cnt_d   = CLEAR_LOAD;
        end
        if (load_clear) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LOAD;
            fill_d  = '0;
        end
    end

    // Control state registers; reset aborts any fill or busy period at once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            ac_q        <= '0;
            id_q        <= 1'b1;
            mode_q      <= 1'b1;
            n_q         <= 1'b0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            rd_q        <= 8'h00;
            drive_q     <= 1'b0;
            violation_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            rd_q        <= rd_d;
            drive_q     <= drive_d;
            violation_q <= violation_d;
        end
    end

    assign lcd_data   = drive_q ? rd_q : 8'hzz;
    assign busy       = busy_w;
    assign display_on = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign violation  = violation_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - self-checking bench for the HD44780 responder
module tb_lcd_hd44780_responder;

    localparam int BUSY_N  = 40;
    localparam int CLEAR_N = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs = 1'b0, rw = 1'b0, e = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    wire  [7:0] lcd_data;
    logic [6:0] mon_addr = 7'h00;
    logic [7:0] mon_data;
    logic       busy, display_on, cursor_on, blink_on, violation;

    assign lcd_data = tb_oe ? tb_dout : 8'hzz;

    lcd_hd44780_responder #(
        .BUSY_CYCLES  (BUSY_N),
        .CLEAR_CYCLES (CLEAR_N)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .lcd_RS      (rs),
        .lcd_RW      (rw),
        .lcd_E       (e),
        .lcd_data    (lcd_data),
        .mon_addr    (mon_addr),
        .mon_data    (mon_data),
        .busy        (busy),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .violation   (violation)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model of the display: memory image, cursor, flags and busy window.
    logic [7:0] m_mem [128];
    logic [7:0] m_pre [128];
    int m_ac = 0, m_id = 1, m_mode = 1, m_d = 0, m_c = 0, m_b = 0;
    int bstart = 0, bend = 0, viol_edge = -1, clear_c = -1000;

    function automatic bit mbusy(input int m);
        return (m >= bstart) && (m < bend);
    endfunction

    function automatic int step_ac(input int a, input int up);
        return (a + (up != 0 ? 1 : 127)) % 128;
    endfunction

    task automatic model_commit(input bit r, input logic [7:0] d);
        int c;
        int n;
        c = cyc;
        n = 0;
        if (mbusy(c - 1)) begin
            viol_edge = c;
            return;
        end
        if (r) begin
            if (m_mode != 0) begin
                m_mem[m_ac] = d;
                m_ac = step_ac(m_ac, m_id);
            end
            n = BUSY_N;
        end else if (d[7]) begin
            m_ac = int'(d[6:0]); m_mode = 1; n = BUSY_N;
        end else if (d[6]) begin
            m_mode = 0; n = BUSY_N;
        end else if (d[5]) begin
            n = BUSY_N;
        end else if (d[4]) begin
            if (!d[3]) m_ac = step_ac(m_ac, int'(d[2]));
            n = BUSY_N;
        end else if (d[3]) begin
            m_d = int'(d[2]); m_c = int'(d[1]); m_b = int'(d[0]); n = BUSY_N;
        end else if (d[2]) begin
            m_id = int'(d[1]); n = BUSY_N;
        end else if (d[1]) begin
            m_ac = 0; n = CLEAR_N;
        end else if (d[0]) begin
            m_pre = m_mem;
            for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
            m_ac = 0; m_id = 1; clear_c = c; n = CLEAR_N;
        end
        if (n > 0) begin
            bstart = c;
            bend   = c + n;
        end
    endtask

    bit go = 1'b0;
    int busy_len = 0;

    // Per-cycle check of the status outputs against the model.
    always @(negedge clk) begin
        if (go) begin
            chk("busy", int'(busy), int'(mbusy(cyc)));
            chk("violation", int'(violation), int'(cyc == viol_edge));
            chk("display_on", int'(display_on), m_d);
            chk("cursor_on", int'(cursor_on), m_c);
            chk("blink_on", int'(blink_on), m_b);
            if (busy) busy_len++;
        end
    end

    task automatic lcd_write(input bit r, input logic [7:0] d);
        @(posedge clk); #1;
        rs = r; rw = 1'b0; tb_dout = d; tb_oe = 1'b1;
        @(posedge clk); #1;
        e = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_commit(r, d);
        tb_oe = 1'b0;
    endtask

    task automatic lcd_read(input bit r, output logic [7:0] got, output logic [7:0] exp);
        int k;
        @(posedge clk); #1;
        rs = r; rw = 1'b1; tb_oe = 1'b0;
        @(posedge clk); #1;
        e = 1'b1;
        k = cyc;
        repeat (3) @(posedge clk);
        #1;
        exp = r ? m_mem[m_ac] : {mbusy(k + 2), 7'(m_ac)};
        @(negedge clk);
        got = lcd_data;
        repeat (2) @(posedge clk);
        #1;
        e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (r) m_ac = step_ac(m_ac, m_id);
        rw = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || cyc < bend) && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_within_bound", int'(guard < 1000), 1);
    endtask

    task automatic mon_read(input logic [6:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        mon_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = mon_data;
    endtask

    task automatic scan_all(input string name);
        logic [7:0] d;
        for (int i = 0; i < 128; i++) begin
            mon_read(7'(i), d);
            chk(name, int'(d), int'(m_mem[i]));
        end
    endtask

    task automatic do_reset(input int hold);
        int r;
        @(posedge clk); #1;
        rst = 1'b1;
        r = cyc;
        if (clear_c >= 0 && r < clear_c + 128) begin
            for (int j = r - clear_c; j < 128; j++) m_mem[j] = m_pre[j];
        end
        m_ac = 0; m_id = 1; m_mode = 1; m_d = 0; m_c = 0; m_b = 0;
        bstart = r; bend = r; viol_edge = -1; clear_c = -1000;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] got, exp, d;

    initial begin
        for (int i = 0; i < 128; i++) begin
            m_mem[i] = 8'h00;
            m_pre[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        go = 1'b1;
        @(negedge clk);
        chk("reset_mon_data", int'(mon_data), 8'h00);
        chk("reset_busy", int'(busy), 0);
        chk("reset_violation", int'(violation), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        lcd_read(1'b0, got, exp);
        chk("status_after_reset", int'(got), int'(exp));
        chk("status_after_reset_lit", int'(got), 8'h00);

        busy_len = 0;
        lcd_write(1'b0, 8'h01);
        wait_idle();
        chk("clear_busy_len", busy_len, 200);
        scan_all("ddram_after_clear");
        mon_read(7'h45, d);
        chk("clear_blank_lit", int'(d), 8'h20);
        lcd_read(1'b0, got, exp);
        chk("status_after_clear_lit", int'(got), 8'h00);

        lcd_write(1'b0, 8'hFF); wait_idle();
        lcd_write(1'b1, 8'h41); wait_idle();
        busy_len = 0;
        lcd_write(1'b1, 8'h42); wait_idle();
        chk("write_busy_len", busy_len, 40);
        mon_read(7'h7F, d);
        chk("ddram_7f_lit", int'(d), 8'h41);
        mon_read(7'h00, d);
        chk("ddram_00_wrap_lit", int'(d), 8'h42);
        lcd_read(1'b0, got, exp);
        chk("status_wrap", int'(got), int'(exp));
        chk("status_wrap_lit", int'(got), 8'h01);

        lcd_write(1'b0, 8'h04); wait_idle();
        lcd_write(1'b0, 8'h80); wait_idle();
        lcd_write(1'b1, 8'h5A); wait_idle();
        mon_read(7'h00, d);
        chk("ddram_00_dec_lit", int'(d), 8'h5A);
        lcd_read(1'b0, got, exp);
        chk("status_dec", int'(got), int'(exp));
        chk("status_dec_lit", int'(got), 8'h7F);

        lcd_write(1'b0, 8'hFF); wait_idle();
        lcd_read(1'b1, got, exp);
        chk("data_read", int'(got), int'(exp));
        chk("data_read_lit", int'(got), 8'h41);
        lcd_read(1'b0, got, exp);
        chk("status_after_data_read_lit", int'(got), 8'h7E);

        lcd_write(1'b0, 8'h06); wait_idle();
        lcd_write(1'b0, 8'h80); wait_idle();
        lcd_write(1'b0, 8'h10); wait_idle();
        lcd_read(1'b0, got, exp);
        chk("shift_left_wrap_lit", int'(got), 8'h7F);
        lcd_write(1'b0, 8'h14); wait_idle();
        lcd_read(1'b0, got, exp);
        chk("shift_right_wrap", int'(got), int'(exp));
        chk("shift_right_wrap_lit", int'(got), 8'h00);

        lcd_write(1'b0, 8'h90); wait_idle();
        lcd_write(1'b1, 8'h33);
        lcd_write(1'b1, 8'h44);
        chk("violation_pulse_lit", int'(violation), 1);
        lcd_read(1'b0, got, exp);
        chk("status_busy", int'(got), int'(exp));
        chk("status_busy_bit_lit", int'(got[7]), 1);
        wait_idle();
        mon_read(7'h10, d);
        chk("ddram_10_lit", int'(d), 8'h33);
        mon_read(7'h11, d);
        chk("ddram_11_untouched_lit", int'(d), 8'h20);
        lcd_read(1'b0, got, exp);
        chk("status_after_violation_lit", int'(got), 8'h11);

        lcd_write(1'b0, 8'h0E); wait_idle();
        chk("display_on_lit", int'(display_on), 1);
        chk("cursor_on_lit", int'(cursor_on), 1);
        chk("blink_on_lit", int'(blink_on), 0);

        lcd_write(1'b0, 8'h01);
        repeat (50) @(posedge clk);
        do_reset(3);
        @(negedge clk);
        chk("busy_after_reset_lit", int'(busy), 0);
        chk("display_after_reset_lit", int'(display_on), 0);
        scan_all("ddram_after_abort");
        mon_read(7'h00, d);
        chk("abort_cleared_00_lit", int'(d), 8'h20);
        mon_read(7'h7F, d);
        chk("abort_kept_7f_lit", int'(d), 8'h41);
        lcd_read(1'b0, got, exp);
        chk("status_after_abort", int'(got), int'(exp));
        chk("status_after_abort_lit", int'(got), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
